// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: N-flop synchronizer, sample-tick debouncer
// and registered rising/falling edge pulses per channel.
`timescale 1ns/1ps
module input_conditioner #(
  parameter int WIDTH          = 1,
  parameter int SYNC_STAGES    = 2,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_signal,
  output logic [WIDTH-1:0] sync_signal,
  output logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] rising_pulse,
  output logic [WIDTH-1:0] falling_pulse
);

  localparam int SCNT_W = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int PCNT_W = (PULSE_CNT_MAX > 1) ? $clog2(PULSE_CNT_MAX + 1) : 1;
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SAMPLE_CNT_MAX - 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_CNT_MAX - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("input_conditioner: SYNC_STAGES must be >= 2");
  end
  if (SAMPLE_CNT_MAX < 1) begin : g_bad_sample
    $error("input_conditioner: SAMPLE_CNT_MAX must be >= 1");
  end
  if (PULSE_CNT_MAX < 1) begin : g_bad_pulse
    $error("input_conditioner: PULSE_CNT_MAX must be >= 1");
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [SCNT_W-1:0]                 sample_cnt_q, sample_cnt_d;
  logic                              tick;
  logic [WIDTH-1:0]                  deb_q, deb_d;
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic [WIDTH-1:0]                  fall_q, fall_d;
  logic [WIDTH-1:0]                  toggle;

  // Plain shift chain: stage 0 is the only flop that sees the raw async input.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_signal};
  end

  always_comb begin
    tick         = (sample_cnt_q == SCNT_LAST);
    sample_cnt_d = tick ? '0 : sample_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= '0;
      sample_cnt_q <= '0;
    end else begin
      sync_q       <= sync_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign sync_signal = sync_q[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [PCNT_W-1:0] cnt_q, cnt_d;
      logic              mismatch;

      // Any return to the current level restarts filtering from zero.
      always_comb begin
        mismatch = sync_signal[gi] ^ deb_q[gi];
        cnt_d    = cnt_q;
        if (!mismatch) begin
          cnt_d = '0;
        end else if (tick) begin
          cnt_d = (cnt_q == PCNT_LAST) ? '0 : cnt_q + 1'b1;
        end
      end

      assign toggle[gi] = mismatch & tick & (cnt_q == PCNT_LAST);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  always_comb begin
    deb_d  = deb_q ^ toggle;
    rise_d = toggle & ~deb_q;
    fall_d = toggle & deb_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      deb_q  <= deb_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign debounced_signal = deb_q;
  assign rising_pulse     = rise_q;
  assign falling_pulse    = fall_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: table of input steps with a pulse scoreboard,
// plus hand-written reset sequences; a second build checks a 3-deep synchronizer.
`timescale 1ns/1ps
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] async_signal = 2'b00;
  logic [1:0] sync_signal, debounced_signal, rising_pulse, falling_pulse;
  logic [1:0] sync3, deb3, rise3, fall3;

  always #5 clk = ~clk;

  input_conditioner #(
    .WIDTH(2), .SYNC_STAGES(2), .SAMPLE_CNT_MAX(4), .PULSE_CNT_MAX(3)
  ) u_dut (
    .clk(clk), .rst(rst), .async_signal(async_signal),
    .sync_signal(sync_signal), .debounced_signal(debounced_signal),
    .rising_pulse(rising_pulse), .falling_pulse(falling_pulse)
  );

  input_conditioner #(
    .WIDTH(2), .SYNC_STAGES(3), .SAMPLE_CNT_MAX(4), .PULSE_CNT_MAX(3)
  ) u_dut3 (
    .clk(clk), .rst(rst), .async_signal(async_signal),
    .sync_signal(sync3), .debounced_signal(deb3),
    .rising_pulse(rise3), .falling_pulse(fall3)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: cycle %0d got %0h required %0h", name, cyc, act, req);
    end
  endtask

  typedef struct {
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] deb;
    int         lo;
    int         hi;
  } evt_t;

  evt_t       sb[$];
  evt_t       mon_e;
  logic [1:0] exp_deb = 2'b00;

  // Every pulse must match the next expected event; otherwise the level must hold.
  always @(negedge clk) begin
    if ((rising_pulse | falling_pulse) != 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {28'd0, rising_pulse, falling_pulse}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_rise", {30'd0, rising_pulse}, {30'd0, mon_e.rise});
        check("pulse_fall", {30'd0, falling_pulse}, {30'd0, mon_e.fall});
        check("pulse_deb_aligned", {30'd0, debounced_signal}, {30'd0, mon_e.deb});
        check("pulse_in_window", {31'd0, (cyc >= mon_e.lo && cyc <= mon_e.hi)}, 32'd1);
        exp_deb = mon_e.deb;
      end
    end else begin
      check("deb_hold", {30'd0, debounced_signal}, {30'd0, exp_deb});
    end
  end

  typedef struct {
    logic [1:0] in;
    int         hold;
    bit         evt;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] deb_after;
  } vec_t;

  vec_t       vecs[8];
  logic [1:0] prev;
  int         prev_hold;
  int         k;
  int         r;

  initial begin
    vecs[0] = '{2'b01, 20, 1'b1, 2'b01, 2'b00, 2'b01};  // clean press
    vecs[1] = '{2'b00, 20, 1'b1, 2'b00, 2'b01, 2'b00};  // release
    vecs[2] = '{2'b01,  6, 1'b0, 2'b00, 2'b00, 2'b00};  // bounce
    vecs[3] = '{2'b00,  2, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[4] = '{2'b01,  6, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[5] = '{2'b00, 20, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[6] = '{2'b11, 20, 1'b1, 2'b11, 2'b00, 2'b11};  // both channels
    vecs[7] = '{2'b00, 20, 1'b1, 2'b00, 2'b11, 2'b00};

    // Reset holds everything at 0 even with inputs high.
    async_signal = 2'b11;
    repeat (3) begin
      @(negedge clk);
      check("rst_sync", {30'd0, sync_signal}, 32'd0);
      check("rst_sync3", {30'd0, sync3}, 32'd0);
      check("rst_deb", {30'd0, debounced_signal}, 32'd0);
      check("rst_pulses", {28'd0, rising_pulse, falling_pulse}, 32'd0);
    end
    async_signal = 2'b00;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    prev      = 2'b00;
    prev_hold = 100;
    for (int v = 0; v < 8; v++) begin
      @(posedge clk); #1;
      async_signal = vecs[v].in;
      k = cyc;
      if (vecs[v].evt)
        sb.push_back('{vecs[v].rise, vecs[v].fall, vecs[v].deb_after, k + 11, k + 14});
      for (int t = 0; t < vecs[v].hold; t++) begin
        @(negedge clk);
        check("sync2", {30'd0, sync_signal}, {30'd0, (t < 2) ? prev : vecs[v].in});
        if (prev_hold >= 3)
          check("sync3_bit0", {31'd0, sync3[0]}, {31'd0, (t < 3) ? prev[0] : vecs[v].in[0]});
      end
      check("deb_level", {30'd0, debounced_signal}, {30'd0, vecs[v].deb_after});
      check("sb_drained", sb.size(), 32'd0);
      $display("vector %0d: in=%b hold=%0d deb=%b", v, vecs[v].in, vecs[v].hold, debounced_signal);
      prev      = vecs[v].in;
      prev_hold = vecs[v].hold;
    end

    // Reset in the middle of a count: exactly two ticks of mismatch seen.
    @(posedge clk); #1;
    async_signal = 2'b01;
    repeat (11) @(negedge clk);
    check("pre_rst_sync", {30'd0, sync_signal}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_sync", {30'd0, sync_signal}, 32'd0);
    check("async_rst_sync3", {30'd0, sync3}, 32'd0);
    check("async_rst_deb", {30'd0, debounced_signal}, 32'd0);
    check("async_rst_pulses", {28'd0, rising_pulse, falling_pulse}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("held_rst_sync", {30'd0, sync_signal}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    r = cyc;
    sb.push_back('{2'b01, 2'b00, 2'b01, r + 11, r + 14});
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      check("post_rst_sync", {30'd0, sync_signal}, (t < 2) ? 32'd0 : 32'd1);
    end
    check("post_rst_deb", {30'd0, debounced_signal}, 32'd1);
    check("post_rst_sb_drained", sb.size(), 32'd0);
    $display("reset mid-count: deb=%b", debounced_signal);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Multi-channel conditioner for asynchronous board inputs (buttons, switches).
- Each channel passes through three stages:
  - a SYNC_STAGES-deep flip-flop synchronizer;
  - a sample-tick debouncer;
  - a rising/falling edge detector.
- Outputs are clean, clk-domain levels and single-cycle pulses that downstream FSMs and counters consume directly.
- Generalises the fixed 2-flop synchronizer: configurable chain depth, debounce filtering and edge outputs.

Parameters:
- WIDTH, 1, number of independent channels.
- SYNC_STAGES, 2, synchronizer flops per channel; must be >= 2.
- SAMPLE_CNT_MAX, 62500, clk cycles per debounce sample tick; must be >= 1.
- PULSE_CNT_MAX, 200, consecutive mismatching ticks required to change the debounced level; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- async_signal  input  WIDTH  raw asynchronous inputs.
- sync_signal  output  WIDTH  synchronizer chain output (last stage).
- debounced_signal  output  WIDTH  filtered level per channel.
- rising_pulse  output  WIDTH  one-cycle pulse on debounced 0->1.
- falling_pulse  output  WIDTH  one-cycle pulse on debounced 1->0.

Behaviour:
- Reset (async assert on rst=1) clears every flop to 0:
  - sync chain, sample counter, per-channel counters, debounced_signal, rising_pulse, falling_pulse.
- Outputs stay 0 while rst=1. No other flop in the block is left unreset.
- Synchronizer:
  - Per-bit chain of SYNC_STAGES flops; no logic between stages.
  - A level change on async_signal[i], stable across edges, appears on sync_signal[i] exactly SYNC_STAGES rising edges later.
- Sample counter:
  - Shared across channels; width $clog2(SAMPLE_CNT_MAX), minimum 1.
  - Counts 0..SAMPLE_CNT_MAX-1 and wraps to 0.
  - Internal tick = 1 during the cycle when count == SAMPLE_CNT_MAX-1.
  - SAMPLE_CNT_MAX=1 gives a tick every cycle.
- Per-channel debounce counter cnt[i]:
  - Width $clog2(PULSE_CNT_MAX+1).
  - Rules evaluated each cycle, in priority order:
    1. sync_signal[i] == debounced_signal[i]: cnt[i] <= 0, regardless of tick (any glitch back restarts filtering).
    2. Mismatch and tick and cnt[i] == PULSE_CNT_MAX-1: debounced_signal[i] toggles, cnt[i] <= 0.
    3. Mismatch and tick otherwise: cnt[i] <= cnt[i]+1.
    4. Mismatch, no tick: hold.
  - cnt[i] never exceeds PULSE_CNT_MAX-1; no wrap.
- Edge pulses:
  - Registered, asserted in the same cycle debounced_signal shows its new value, for exactly 1 cycle.
  - rising_pulse[i] = toggle event with new value 1; falling_pulse[i] = toggle event with new value 0.
  - Never both high on one channel.
  - Back-to-back toggles cannot occur (minimum PULSE_CNT_MAX ticks apart).
- Latency: a clean input step changes debounced_signal between SYNC_STAGES + (PULSE_CNT_MAX-1)*SAMPLE_CNT_MAX + 1 and SYNC_STAGES + PULSE_CNT_MAX*SAMPLE_CNT_MAX edges after the step. Exact value depends on tick phase.
- Channels are fully independent apart from the shared tick.
- Simultaneous events on multiple channels each toggle and pulse in the same cycle.
- Reset mid-operation:
  - Discards partial counts and in-flight synchronizer bits.
  - After release, an input held at 1 re-enters the synchronizer and is debounced from zero.
  - A rising_pulse follows, since debounced restarts at 0.
- Parameter violations (SYNC_STAGES<2, SAMPLE_CNT_MAX<1 or PULSE_CNT_MAX<1) trigger $error at elaboration.

Test Plan (WIDTH=2, SYNC_STAGES=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3 unless stated):
- Synchronizer depth: SYNC_STAGES=3 build, step async_signal[0] 0->1.
  - Required: sync_signal[0] = 1 exactly 3 edges later (checked 1 ns after edge), not at 2.
  - Same requirement for the 1->0 step.
- Clean press: async_signal[0] 0->1 held.
  - Required: debounced_signal[0] = 1 between 11 and 14 edges after the step.
  - Required: rising_pulse[0] high exactly 1 cycle, aligned with the debounced rise.
  - Required: channel 1 outputs stay 0.
- Bounce rejection: async_signal[0] high for 6 cycles, low 2, high 6, then low.
  - Required: debounced_signal[0], rising_pulse[0] and falling_pulse[0] never assert.
- Release: from debounced=1, drop async_signal[0] and hold.
  - Required: falling_pulse[0] one cycle, debounced_signal[0] = 0 within 14 edges.
  - Required: rising_pulse[0] stays 0 throughout.
- Simultaneous channels: step both bits 00->11 in one cycle.
  - Required: both debounced bits rise in the same cycle.
  - Required: rising_pulse = 2'b11 for one cycle.
- Reset mid-count: assert rst (between edges) after 2 ticks of mismatch, input still 1.
  - Required: all outputs 0 immediately, without waiting for an edge.
  - Required after release: sync_signal = 1 after 2 edges, debounced rise at 11..14 edges, with rising_pulse.
